// File: rtl/conv_window_loader.sv
// Serial-to-parallel window loader: packs D*F*F streamed elements (element 0 in LSBs) for the conv unit.
// WINDOW_DBUF_EN selects ping-pong window buffers; undefined gives a single buffer with a FILL/FULL FSM.
module conv_window_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [D*F*F*DATA_WIDTH-1:0]    out_window,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(D*F*F+1)-1:0]     fill_count
);

  localparam int N  = D * F * F;
  localparam int CW = $clog2(N + 1);
  localparam int WW = N * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign fill_count = cnt_q;

`ifdef WINDOW_DBUF_EN

  logic [WW-1:0] buf_q [2];
  logic [WW-1:0] buf_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;

  // Filling always targets wr_sel; if that buffer is still full, both are full.
  assign in_ready   = !full_q[wr_sel_q] && !reset;
  assign out_valid  = full_q[rd_sel_q];
  assign out_window = buf_q[rd_sel_q];

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    if (out_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (flush) begin
      cnt_d = '0;
    end else if (in_fire) begin
      buf_d[wr_sel_q][DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] = in_data;
      if (cnt_q == LAST) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        cnt_d            = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) buf_q[i] <= buf_d[i];
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
    end
  end

`else

  typedef enum logic {FILL, FULL} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] win_q, win_d;

  assign in_ready   = (state_q == FILL) && !reset;
  assign out_valid  = (state_q == FULL);
  assign out_window = win_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        // flush wins over a same-cycle transfer; the element is dropped
        if (flush) begin
          cnt_d = '0;
        end else if (in_fire) begin
          win_d[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] = in_data;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

`endif

endmodule

// File: tb/tb_conv_window_loader.sv
// Self-checking bench for conv_window_loader (single-buffer build, D=1, F=2, N=4).
module tb_conv_window_loader;

  localparam int DW = 16;
  localparam int D  = 1;
  localparam int F  = 2;
  localparam int N  = D * F * F;
  localparam int CW = $clog2(N + 1);
  localparam int WW = N * DW;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] out_window;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fill_count;

  int total = 0;
  int bad   = 0;

  // Reference model: elements of the window being collected, plus the held completed window.
  logic [DW-1:0] mq[$];
  bit            m_full;
  logic [WW-1:0] m_win;

  conv_window_loader #(.DATA_WIDTH(DW), .D(D), .F(F)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready),
    .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_q();
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[DW*k +: DW] = mq[k];
    return w;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_full));
    chk("fill_count", 64'(fill_count), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(!m_full));
    if (m_full) chk("out_window", 64'(out_window), 64'(m_win));
  endtask

  // One clock: drive at negedge, update the model at the edge, check just after.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1 chk("in_ready_pre", 64'(in_ready), 64'(!m_full));
    @(posedge clk);
    if (m_full) begin
      if (ordy) m_full = 0;
    end else if (fl) begin
      mq.delete();
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() == N) begin
        m_win  = pack_q();
        m_full = 1;
        mq.delete();
      end
    end
    #1 check_outputs();
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_count", 64'(fill_count), 64'd0);
    chk("rst_out_window", 64'(out_window), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    mq.delete();
    m_full = 0;
    m_win  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_full = 0; m_win = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fill_count", 64'(fill_count), 64'd0);
    chk("reset_out_window", 64'(out_window), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic fill
    for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0);
    chk("basic_window", 64'(out_window), 64'h0004_0003_0002_0001);
    chk("basic_valid", 64'(out_valid), 64'd1);

    // Hold with pressure on the input, then release
    repeat (10) step(1, 16'h9999, 0, 0);
    chk("hold_window", 64'(out_window), 64'h0004_0003_0002_0001);
    step(0, 16'h0, 1, 0);
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Gaps then flush
    step(1, 16'hAAAA, 0, 0);
    step(1, 16'hBBBB, 0, 0);
    repeat (3) step(0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 1);
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h3333, 0, 0);
    step(1, 16'h4444, 0, 0);
    chk("flush_window", 64'(out_window), 64'h4444_3333_2222_1111);
    step(0, 16'h0, 1, 0);

    // Flush vs simultaneous transfer
    step(1, 16'h5555, 0, 0);
    step(1, 16'h6666, 0, 1);
    chk("flush_xfer_count", 64'(fill_count), 64'd0);
    for (int i = 7; i <= 10; i++) step(1, 16'(i), 0, 0);
    chk("after_flush_window", 64'(out_window), 64'h000A_0009_0008_0007);
    step(0, 16'h0, 1, 0);

    // Reset mid-fill and while a window is pending
    for (int i = 0; i < 3; i++) step(1, 16'(16'h0100 + i), 0, 0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1, 16'(16'h0200 + i), 0, 0);
    chk("post_reset_window", 64'(out_window), 64'h0203_0202_0201_0200);
    async_reset();
    for (int i = 0; i < 4; i++) step(1, 16'(16'h0300 + i), 0, 0);
    step(0, 16'h0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
